// File: rtl/alu_result_stage.sv
// ALU result stage: tracks issued ALU ops through the ALU latency,
// queues {tag,data,status} in a FWFT FIFO and holds HI/LO and overflow.
module alu_result_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int CTRL_WIDTH   = 4,
  parameter int STATUS_WIDTH = 4,
  parameter int TAG_WIDTH    = 5,
  parameter int DELAY        = 0,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [CTRL_WIDTH-1:0]   issue_ctrl,
  input  logic [TAG_WIDTH-1:0]    issue_tag,
  input  logic [DATA_WIDTH-1:0]   alu_dataOut,
  input  logic [STATUS_WIDTH-1:0] alu_status,
  input  logic [DATA_WIDTH-1:0]   alu_hi,
  input  logic [DATA_WIDTH-1:0]   alu_lo,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [TAG_WIDTH-1:0]    res_tag,
  output logic [DATA_WIDTH-1:0]   res_data,
  output logic [STATUS_WIDTH-1:0] res_status,
  output logic [DATA_WIDTH-1:0]   hi_q,
  output logic [DATA_WIDTH-1:0]   lo_q,
  output logic                    ovf_sticky,
  input  logic                    ovf_clr,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int CW = AW + 2;
  localparam logic [CTRL_WIDTH-1:0] MULT = CTRL_WIDTH'(4'h6);

  logic                  acc;
  logic                  cap_v;
  logic [CTRL_WIDTH-1:0] cap_ctrl;
  logic [TAG_WIDTH-1:0]  cap_tag;
  logic [CW-1:0]         inflight;
  logic [OW-1:0]         occ;
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  push;
  logic                  pop;
  logic                  full;

  logic [TAG_WIDTH-1:0]    tag_m  [DEPTH];
  logic [DATA_WIDTH-1:0]   data_m [DEPTH];
  logic [STATUS_WIDTH-1:0] stat_m [DEPTH];

  assign issue_ready = !rst &&
    ((CW'(occ) + inflight) < CW'(DEPTH));
  assign acc  = issue_valid & issue_ready;
  assign push = cap_v;
  assign pop  = res_valid & res_ready;
  assign full = (occ == OW'(DEPTH));

  generate
    if (DELAY == 0) begin : g_comb
      assign cap_v    = acc;
      assign cap_ctrl = issue_ctrl;
      assign cap_tag  = issue_tag;
      assign inflight = '0;
    end else begin : g_pipe
      logic                  sv [DELAY];
      logic [CTRL_WIDTH-1:0] sc [DELAY];
      logic [TAG_WIDTH-1:0]  st [DELAY];

      // shift accepted ops along the ALU latency
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DELAY; i++) begin
            sv[i] <= 1'b0;
            sc[i] <= '0;
            st[i] <= '0;
          end
        end else begin
          sv[0] <= acc;
          sc[0] <= issue_ctrl;
          st[0] <= issue_tag;
          for (int i = 1; i < DELAY; i++) begin
            sv[i] <= sv[i-1];
            sc[i] <= sc[i-1];
            st[i] <= st[i-1];
          end
        end
      end

      // count ops still travelling through the ALU
      always_comb begin
        inflight = '0;
        for (int i = 0; i < DELAY; i++)
          inflight = inflight + CW'(sv[i]);
      end

      assign cap_v    = sv[DELAY-1];
      assign cap_ctrl = sc[DELAY-1];
      assign cap_tag  = st[DELAY-1];
    end
  endgenerate

  // result storage; contents are qualified by occupancy
  always_ff @(posedge clk) begin
    if (push) begin
      tag_m[wptr]  <= cap_tag;
      data_m[wptr] <= alu_dataOut;
      stat_m[wptr] <= alu_status;
    end
  end

  // fifo pointers and entry count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)
        occ <= occ + OW'(1);
      else if (pop && !push)
        occ <= occ - OW'(1);
    end
  end

  // architectural HI/LO and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q       <= '0;
      lo_q       <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (cap_v && cap_ctrl == MULT) begin
        hi_q <= alu_hi;
        lo_q <= alu_lo;
      end
      if (cap_v && alu_status[3])
        ovf_sticky <= 1'b1;
      else if (ovf_clr)
        ovf_sticky <= 1'b0;
    end
  end

  assign occupancy  = occ;
  assign res_valid  = (occ != '0);
  assign res_tag    = res_valid ? tag_m[rptr]  : '0;
  assign res_data   = res_valid ? data_m[rptr] : '0;
  assign res_status = res_valid ? stat_m[rptr] : '0;

  // a push into a full fifo means the credit logic is broken
  always @(posedge clk) begin
    if (!rst)
      assert (!(push && full && !pop));
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: DELAY=0 and DELAY=2 instances driven
// together, checked against a queue-based reference model.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic [3:0]  ictrl = '0;
  logic [4:0]  itag = '0;
  logic [31:0] ad = '0;
  logic [3:0]  ast = '0;
  logic [31:0] ahi = '0;
  logic [31:0] alo = '0;
  logic        rr = 1'b0;
  logic        clr = 1'b0;

  logic        ir   [2];
  logic        rv   [2];
  logic [4:0]  rt   [2];
  logic [31:0] rd   [2];
  logic [3:0]  rs   [2];
  logic [31:0] hq   [2];
  logic [31:0] lq   [2];
  logic        ov   [2];
  logic [2:0]  oc   [2];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.DELAY(0), .DEPTH(4)) u0 (
    .clk(clk), .rst(rst),
    .issue_valid(iv), .issue_ready(ir[0]),
    .issue_ctrl(ictrl), .issue_tag(itag),
    .alu_dataOut(ad), .alu_status(ast),
    .alu_hi(ahi), .alu_lo(alo),
    .res_valid(rv[0]), .res_ready(rr),
    .res_tag(rt[0]), .res_data(rd[0]),
    .res_status(rs[0]),
    .hi_q(hq[0]), .lo_q(lq[0]),
    .ovf_sticky(ov[0]), .ovf_clr(clr),
    .occupancy(oc[0])
  );

  alu_result_stage #(.DELAY(2), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst),
    .issue_valid(iv), .issue_ready(ir[1]),
    .issue_ctrl(ictrl), .issue_tag(itag),
    .alu_dataOut(ad), .alu_status(ast),
    .alu_hi(ahi), .alu_lo(alo),
    .res_valid(rv[1]), .res_ready(rr),
    .res_tag(rt[1]), .res_data(rd[1]),
    .res_status(rs[1]),
    .hi_q(hq[1]), .lo_q(lq[1]),
    .ovf_sticky(ov[1]), .ovf_clr(clr),
    .occupancy(oc[1])
  );

  typedef struct {
    int         cap;
    logic [3:0] ctrl;
    logic [4:0] tag;
  } pend_t;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
    logic [3:0]  st;
  } ent_t;

  pend_t       pq [2][$];
  ent_t        fq [2][$];
  logic [31:0] mhi [2];
  logic [31:0] mlo [2];
  logic        movf [2];
  int          dly [2];

  task automatic chk(string nm, logic [31:0] o,
                     logic [31:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s obs=%0h exp=%0h", nm, o, e);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pq[d].delete();
      fq[d].delete();
      mhi[d]  = '0;
      mlo[d]  = '0;
      movf[d] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d valid", d), 32'(rv[d]),
          32'(fq[d].size() > 0));
      chk($sformatf("d%0d occ", d), 32'(oc[d]),
          32'(fq[d].size()));
      if (fq[d].size() > 0) begin
        chk($sformatf("d%0d tag", d), 32'(rt[d]),
            32'(fq[d][0].tag));
        chk($sformatf("d%0d data", d), rd[d],
            fq[d][0].data);
        chk($sformatf("d%0d stat", d), 32'(rs[d]),
            32'(fq[d][0].st));
      end else begin
        chk($sformatf("d%0d tag0", d), 32'(rt[d]), 0);
        chk($sformatf("d%0d data0", d), rd[d], 0);
      end
      chk($sformatf("d%0d hi", d), hq[d], mhi[d]);
      chk($sformatf("d%0d lo", d), lq[d], mlo[d]);
      chk($sformatf("d%0d ovf", d), 32'(ov[d]),
          32'(movf[d]));
    end
  endtask

  // one clock: check credits, advance model, clock, compare
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      logic  rdy;
      logic  capo;
      pend_t p;
      rdy = (fq[d].size() + pq[d].size()) < 4;
      chk($sformatf("d%0d ready", d), 32'(ir[d]),
          32'(rdy));
      if (fq[d].size() > 0 && rr)
        void'(fq[d].pop_front());
      if (iv && rdy)
        pq[d].push_back('{cyc + dly[d], ictrl, itag});
      capo = 1'b0;
      if (pq[d].size() > 0 && pq[d][0].cap == cyc) begin
        p = pq[d].pop_front();
        fq[d].push_back('{p.tag, ad, ast});
        if (p.ctrl == 4'h6) begin
          mhi[d] = ahi;
          mlo[d] = alo;
        end
        capo = ast[3];
      end
      if (capo) movf[d] = 1'b1;
      else if (clr) movf[d] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic idle(int n);
    iv = 1'b0;
    rr = 1'b1;
    clr = 1'b0;
    ast = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iv  = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst ready", d), 32'(ir[d]), 0);
      chk($sformatf("d%0d rst valid", d), 32'(rv[d]), 0);
      chk($sformatf("d%0d rst occ", d), 32'(oc[d]), 0);
      chk($sformatf("d%0d rst hi", d), hq[d], 0);
      chk($sformatf("d%0d rst lo", d), lq[d], 0);
      chk($sformatf("d%0d rst ovf", d), 32'(ov[d]), 0);
      chk($sformatf("d%0d rst data", d), rd[d], 0);
      chk($sformatf("d%0d rst tag", d), 32'(rt[d]), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d rel ready", d), 32'(ir[d]), 1);
  endtask

  initial begin
    dly[0] = 0;
    dly[1] = 2;
    model_reset();
    #12;
    do_reset();

    // single op lands next cycle
    iv = 1'b1; ictrl = 4'h4; itag = 5'd3;
    ad = 32'd5; ast = 4'h0; rr = 1'b0;
    step();
    chk("t2 valid", 32'(rv[0]), 1);
    chk("t2 tag", 32'(rt[0]), 3);
    chk("t2 data", rd[0], 5);
    chk("t2 occ", 32'(oc[0]), 1);
    idle(4);

    // mult updates HI/LO, other ops do not
    iv = 1'b1; ictrl = 4'h6; itag = 5'd1;
    ahi = 32'd1; alo = 32'hFFFF_FFFE;
    step();
    chk("t3 hi", hq[0], 1);
    chk("t3 lo", lq[0], 32'hFFFF_FFFE);
    ictrl = 4'h0; ahi = 32'd9; alo = 32'd9;
    step();
    chk("t3 hi keep", hq[0], 1);
    chk("t3 lo keep", lq[0], 32'hFFFF_FFFE);
    idle(5);

    // fill to depth with consumer stalled, then drain in order
    rr = 1'b0; ictrl = 4'h1;
    for (int k = 0; k < 6; k++) begin
      iv = 1'b1;
      itag = 5'(k);
      ad = $urandom;
      step();
    end
    iv = 1'b0;
    chk("t4 occ", 32'(oc[0]), 4);
    chk("t4 ready", 32'(ir[0]), 0);
    rr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t4 order", 32'(rt[0]), k);
      step();
    end
    chk("t4 empty", 32'(rv[0]), 0);
    idle(4);

    // DELAY=2 latency and credits with ops in flight
    rr = 1'b0; iv = 1'b1; itag = 5'd7;
    step();
    iv = 1'b0;
    chk("t5 c1", 32'(rv[1]), 0);
    step();
    chk("t5 c2", 32'(rv[1]), 0);
    step();
    chk("t5 c3", 32'(rv[1]), 1);
    idle(4);
    rr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      iv = 1'b1;
      itag = 5'(k + 8);
      step();
    end
    iv = 1'b0;
    chk("t5 occ3", 32'(oc[1]), 3);
    chk("t5 noready", 32'(ir[1]), 0);
    idle(6);

    // push+pop holds occupancy; set beats clear
    rr = 1'b0; iv = 1'b1;
    step();
    step();
    rr = 1'b1;
    step();
    chk("t6 occ", 32'(oc[0]), 2);
    ast = 4'h8; clr = 1'b1;
    step();
    chk("t6 ovf", 32'(ov[0]), 1);
    iv = 1'b0; ast = 4'h0;
    step();
    chk("t6 clr", 32'(ov[0]), 0);
    idle(4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      iv    = 1'($urandom);
      ictrl = 4'($urandom_range(0, 7));
      itag  = 5'($urandom);
      ad    = $urandom;
      ast   = 4'($urandom);
      ahi   = $urandom;
      alo   = $urandom;
      rr    = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 7) == 0);
      step();
    end
    idle(6);

    // reset with entries queued and a mult in flight
    rr = 1'b0; clr = 1'b0; ast = 4'h0;
    iv = 1'b1; ictrl = 4'h6; ahi = 32'd7;
    step();
    ictrl = 4'h0;
    step();
    ictrl = 4'h6;
    step();
    chk("t1 hi7", hq[0], 7);
    chk("t1 occ3", 32'(oc[0]), 3);
    do_reset();
    idle(3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
